// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the BCD-to-binary converter
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} b2b_state_t;
  localparam int DIGIT_W = 4;
  localparam logic [3:0] ADJ_THRESH = 4'd8;
  localparam logic [3:0] ADJ_SUB = 4'd3;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/bcd_digit_sub3.sv
// bcd_digit_sub3: one BCD digit correction step, subtract 3 when the digit is 8 or more
module bcd_digit_sub3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);
  assign q = (d >= ADJ_THRESH) ? d - ADJ_SUB : d;
endmodule

// File: rtl/bcd2binary_seq.sv
// bcd2binary_seq: iterative reverse double-dabble BCD-to-binary converter; digit range check enabled by BCD2BIN_ERR_CHECK_EN
module bcd2binary_seq
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int BIN_W = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] bcd_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BIN_W-1:0]              out_bin,
  output logic                          out_err
);
  localparam int BCD_W = DIGIT_W * NUM_DIGITS;
  localparam int SR_W = BCD_W + BIN_W;
  localparam int CW = clog2(BIN_W + 1);
  b2b_state_t state;
  logic [CW-1:0] cnt;
  logic [SR_W-1:0] sr, shifted, nxt;
  logic accept, last;
  assign accept = in_valid && in_ready;
  assign last = cnt == CW'(BIN_W - 1);
  assign shifted = sr >> 1;
  assign nxt[BIN_W-1:0] = shifted[BIN_W-1:0];
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_digit_sub3 u_sub3 (
      .d(shifted[BIN_W+DIGIT_W*g +: DIGIT_W]),
      .q(nxt[BIN_W+DIGIT_W*g +: DIGIT_W])
    );
  end
`ifdef BCD2BIN_ERR_CHECK_EN
  logic err, err_in;
  // any digit above 9 marks the incoming value as malformed
  always_comb begin
    err_in = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) err_in = err_in | (bcd_in[DIGIT_W*i +: DIGIT_W] > 4'd9);
  end
  // latch the error on accept and present it alongside the result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err <= 1'b0;
      out_err <= 1'b0;
    end else if (state == IDLE && accept) err <= err_in;
    else if (state == SHIFT && last) out_err <= err;
    else if (state == DONE && out_ready) out_err <= 1'b0;
`else
  assign out_err = 1'b0;
`endif
  // conversion FSM: load, shift-and-adjust BIN_W times, hold result until taken
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      out_bin <= '0;
      sr <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE:
          if (accept) begin
            sr <= {bcd_in, {BIN_W{1'b0}}};
            cnt <= '0;
            in_ready <= 1'b0;
            state <= SHIFT;
          end else in_ready <= 1'b1;
        SHIFT: begin
          sr <= nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            out_bin <= nxt[BIN_W-1:0];
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE:
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready <= 1'b1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_bcd2binary_seq.sv
// tb_bcd2binary_seq: scoreboard bench for bcd2binary_seq; expected out_err follows BCD2BIN_ERR_CHECK_EN
module tb_bcd2binary_seq;
  localparam int ND = 3;
  localparam int BW = 10;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_err;
  logic [4*ND-1:0] bcd_in = '0;
  logic [BW-1:0] out_bin;
  typedef struct {int bin; int err; bit check_bin;} exp_t;
  exp_t sb[$];
  int total = 0, passed = 0, or_mode = 0, negs = 0, acc_neg = 0;
  bit acc_pend = 0, prev_ov = 0;

  bcd2binary_seq #(.NUM_DIGITS(ND), .BIN_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .bcd_in(bcd_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t model(input logic [4*ND-1:0] b);
    exp_t r;
    int v = 0, e = 0;
    logic [3:0] d;
    for (int i = ND - 1; i >= 0; i--) begin
      d = b[4*i +: 4];
      if (d > 9) e = 1;
      v = v * 10 + int'(d);
    end
    r.bin = v % (1 << BW);
`ifdef BCD2BIN_ERR_CHECK_EN
    r.err = e;
`else
    r.err = 0;
`endif
    r.check_bin = (e == 0);
    return r;
  endfunction

  function automatic logic [4*ND-1:0] to_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  task automatic send(input logic [4*ND-1:0] b, input bit push);
    int n = 0;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    bcd_in = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    if (push) sb.push_back(model(b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    bcd_in = 12'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (sb.size() == 0 && in_ready) break;
      n++;
      if (n > 500) begin
        chk("drain_timeout", sb.size(), 0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // out_ready pattern: 0 = always ready, 1 = random stalls, 2 = held low
  initial forever begin
    @(posedge clk);
    #2;
    out_ready = (or_mode == 0) ? 1'b1 : (or_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
  end

  // monitor: latency of each result and scoreboard comparison on every output handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      negs++;
      if (!rst_n) begin
        acc_pend = 0;
        prev_ov = 0;
      end else begin
        if (in_valid && in_ready) begin
          acc_pend = 1;
          acc_neg = negs;
        end
        if (out_valid && !prev_ov) begin
          if (acc_pend) chk("latency", negs - acc_neg, BW + 1);
          else chk("valid_without_accept", 1, 0);
          acc_pend = 0;
        end
        prev_ov = out_valid;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) chk("unexpected_out", 1, 0);
          else begin
            e = sb.pop_front();
            chk("out_err", int'(out_err), e.err);
            if (e.check_bin) chk("out_bin", int'(out_bin), e.bin);
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_bin", int'(out_bin), 0);
    chk("rst_out_err", int'(out_err), 0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_edge", int'(in_ready), 0);
    @(negedge clk);
    chk("in_ready_after_edge", int'(in_ready), 1);
    @(posedge clk);
    #1;
    or_mode = 0;
    send(12'h255, 1);
    send(12'h999, 1);
    send(12'h000, 1);
    wait_idle();
    or_mode = 2;
    send(12'h407, 1);
    n = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      n++;
      if (n > 50) begin
        chk("bp_valid_timeout", 0, 1);
        break;
      end
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      bcd_in = 12'h111;
      @(negedge clk);
      chk("bp_out_bin", int'(out_bin), 407);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    or_mode = 0;
    wait_idle();
    repeat (20) @(posedge clk);
    #1;
    send(12'h876, 0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_out_bin", int'(out_bin), 0);
    chk("midrst_out_err", int'(out_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(12'h128, 1);
    wait_idle();
    chk("post_rst_bin", int'(out_bin), 128);
    send(12'h1A5, 1);
    wait_idle();
    send(12'h105, 1);
    wait_idle();
    chk("err_clear_bin", int'(out_bin), 105);
    or_mode = 1;
    for (int i = 0; i < 1000; i++) send(to_bcd(i), 1);
    wait_idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
